// File: rtl/sap1_controller_sequencer_if.sv
// Control-bus bundle between the SAP-1 controller-sequencer and the datapath.
// The master modport is the controller; the slave is the datapath side.
interface sap1_controller_sequencer_if;
  logic [3:0] opcode;
  logic       Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT;
  logic [5:0] t_state;

  modport master (
    input  opcode,
    output Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT, t_state
  );

  modport slave (
    output opcode,
    input  Cp, Ep, nLm, nCE, nLi, nEi, nLa, Ea, Su, Eu, nLb, nLo, HLT, t_state
  );
endinterface

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: a six-state one-hot ring plus an opcode decoder.
// The ring and halt flag are registered; the control word is a decode of them.
module sap1_controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input logic                         CLK,
  input logic                         nCLR,
  sap1_controller_sequencer_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } ring_t;

  ring_t ring;
  logic  halted;

  // Halt is taken on the edge leaving T4, so the ring lands on T5 and stays.
  always_ff @(posedge CLK) begin
    if (!nCLR) begin
      ring   <= T1;
      halted <= 1'b0;
    end else if (!halted) begin
      unique case (ring)
        T1:      ring <= T2;
        T2:      ring <= T3;
        T3:      ring <= T4;
        T4:      ring <= T5;
        T5:      ring <= T6;
        T6:      ring <= T1;
        default: ring <= T1;
      endcase
      if (ring == T4 && bus.opcode == OP_HLT) halted <= 1'b1;
    end
  end

  logic cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo;
  logic run;

  assign run = nCLR && !halted;

  // Decoded in active-high form; active-low pins are inverted at the boundary.
  always_comb begin
    {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo} = '0;
    if (run) begin
      unique case (ring)
        T1: begin ep = 1'b1; lm = 1'b1; end
        T2: cp = 1'b1;
        T3: begin ce = 1'b1; li = 1'b1; end
        T4: begin
          if (bus.opcode == OP_LDA || bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ei = 1'b1;
            lm = 1'b1;
          end else if (bus.opcode == OP_OUT) begin
            ea = 1'b1;
            lo = 1'b1;
          end
        end
        T5: begin
          if (bus.opcode == OP_LDA) begin
            ce = 1'b1;
            la = 1'b1;
          end else if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            ce = 1'b1;
            lb = 1'b1;
          end
        end
        T6: begin
          if (bus.opcode == OP_ADD || bus.opcode == OP_SUB) begin
            eu = 1'b1;
            la = 1'b1;
            su = (bus.opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Cp      = cp;
  assign bus.Ep      = ep;
  assign bus.nLm     = ~lm;
  assign bus.nCE     = ~ce;
  assign bus.nLi     = ~li;
  assign bus.nEi     = ~ei;
  assign bus.nLa     = ~la;
  assign bus.Ea      = ea;
  assign bus.Su      = su;
  assign bus.Eu      = eu;
  assign bus.nLb     = ~lb;
  assign bus.nLo     = ~lo;
  assign bus.HLT     = halted && nCLR;
  assign bus.t_state = ring;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer: a step/halt model checked
// every cycle, plus literal expectations at the interesting T-states.
module tb_sap1_controller_sequencer;

  logic CLK = 1'b0;
  logic nCLR;
  sap1_controller_sequencer_if bif ();

  sap1_controller_sequencer dut (
    .CLK  (CLK),
    .nCLR (nCLR),
    .bus  (bif)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Active-high view of the control word, bit 11..0:
  // Cp Ep Lm CE Li Ei La Ea Su Eu Lb Lo
  localparam int B_CP = 11, B_EP = 10, B_LM = 9, B_CE = 8, B_LI = 7, B_EI = 6;
  localparam int B_LA = 5, B_EA = 4, B_SU = 3, B_EU = 2, B_LB = 1, B_LO = 0;

  function automatic logic [11:0] dut_act();
    return {bif.Cp, bif.Ep, ~bif.nLm, ~bif.nCE, ~bif.nLi, ~bif.nEi,
            ~bif.nLa, bif.Ea, bif.Su, bif.Eu, ~bif.nLb, ~bif.nLo};
  endfunction

  // Model: step counts 0..5 through the instruction; halted freezes it.
  int   m_step   = 0;
  bit   m_halted = 1'b0;
  bit   live     = 1'b0;

  always @(posedge CLK) begin
    if (!nCLR) begin
      m_step   = 0;
      m_halted = 1'b0;
      live     = 1'b1;
    end else if (!m_halted) begin
      if (m_step == 3 && bif.opcode == 4'hF) m_halted = 1'b1;
      m_step = (m_step + 1) % 6;
    end
  end

  function automatic logic [11:0] model_act(int step, logic [3:0] opc, logic clr, bit hlt);
    logic [11:0] a = '0;
    if (clr && !hlt) begin
      if (step == 0) begin a[B_EP] = 1; a[B_LM] = 1; end
      if (step == 1) a[B_CP] = 1;
      if (step == 2) begin a[B_CE] = 1; a[B_LI] = 1; end
      if (step == 3 && (opc == 4'h0 || opc == 4'h1 || opc == 4'h2)) begin a[B_EI] = 1; a[B_LM] = 1; end
      if (step == 3 && opc == 4'hE) begin a[B_EA] = 1; a[B_LO] = 1; end
      if (step == 4 && opc == 4'h0) begin a[B_CE] = 1; a[B_LA] = 1; end
      if (step == 4 && (opc == 4'h1 || opc == 4'h2)) begin a[B_CE] = 1; a[B_LB] = 1; end
      if (step == 5 && (opc == 4'h1 || opc == 4'h2)) begin
        a[B_EU] = 1; a[B_LA] = 1; a[B_SU] = (opc == 4'h2);
      end
    end
    return a;
  endfunction

  always @(negedge CLK) begin
    if (live) begin
      int drv;
      chk("ctrl_word", {20'd0, dut_act()}, {20'd0, model_act(m_step, bif.opcode, nCLR, m_halted)});
      chk("t_state", {26'd0, bif.t_state}, {26'd0, 6'b1 << m_step});
      chk("HLT", {31'd0, bif.HLT}, {31'd0, m_halted && nCLR});
      drv = int'(bif.Ep) + int'(!bif.nCE) + int'(!bif.nEi) + int'(bif.Ea) + int'(bif.Eu);
      chk("bus_excl", {31'd0, drv <= 1}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lo_cnt;
    nCLR = 1'b0;
    bif.opcode = 4'hE;
    tick();
    tick();
    chk("rst_tstate", {26'd0, bif.t_state}, 32'h01);
    chk("rst_nLo", {31'd0, bif.nLo}, 32'd1);
    chk("rst_Ep", {31'd0, bif.Ep}, 32'd0);
    chk("rst_HLT", {31'd0, bif.HLT}, 32'd0);

    // OUT: release reset inside T1, Ep rises immediately
    nCLR = 1'b1;
    #1;
    chk("t1_Ep", {31'd0, bif.Ep}, 32'd1);
    lo_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (!bif.nLo) lo_cnt++;
      if (i == 3) chk("out_t4_Ea", {31'd0, bif.Ea}, 32'd1);
      tick();
      if (i == 0) chk("t2_after_rst", {26'd0, bif.t_state}, 32'h02);
    end
    chk("out_nLo_pulses", lo_cnt, 32'd1);
    chk("out_back_T1", {26'd0, bif.t_state}, 32'h01);

    // ADD then SUB
    bif.opcode = 4'h1;
    repeat (4) tick();
    chk("add_t5_nLb", {31'd0, bif.nLb}, 32'd0);
    chk("add_t5_nCE", {31'd0, bif.nCE}, 32'd0);
    tick();
    chk("add_t6", {29'd0, bif.Eu, bif.nLa, bif.Su}, 32'b100);
    tick();
    bif.opcode = 4'h2;
    repeat (5) tick();
    chk("sub_t6", {29'd0, bif.Eu, bif.nLa, bif.Su}, 32'b101);
    tick();

    // LDA with a different opcode during fetch (must be ignored)
    bif.opcode = 4'hE;
    repeat (3) tick();
    bif.opcode = 4'h0;
    #1;
    chk("lda_t4", {30'd0, bif.nEi, bif.nLm}, 32'b00);
    chk("lda_t4_nLo", {31'd0, bif.nLo}, 32'd1);
    tick();
    chk("lda_t5", {30'd0, bif.nCE, bif.nLa}, 32'b00);
    repeat (2) tick();

    // Undefined opcode: idle execute, ring still wraps
    bif.opcode = 4'h7;
    repeat (6) tick();
    chk("nop_wrap", {26'd0, bif.t_state}, 32'h01);

    // HLT
    bif.opcode = 4'hF;
    repeat (4) tick();
    chk("hlt_flag", {31'd0, bif.HLT}, 32'd1);
    chk("hlt_tstate", {26'd0, bif.t_state}, 32'h10);
    bif.opcode = 4'h1;
    repeat (22) tick();
    chk("hlt_held", {25'd0, bif.HLT, bif.t_state}, {25'd0, 1'b1, 6'h10});
    chk("hlt_idle_nLb", {31'd0, bif.nLb}, 32'd1);
    nCLR = 1'b0;
    tick();
    chk("hlt_exit", {25'd0, bif.HLT, bif.t_state}, {25'd0, 1'b0, 6'h01});
    nCLR = 1'b1;

    // Reset in T5 of ADD
    bif.opcode = 4'h1;
    repeat (4) tick();
    chk("mid_t5_nLb", {31'd0, bif.nLb}, 32'd0);
    nCLR = 1'b0;
    #1;
    chk("mid_gated_nLb", {31'd0, bif.nLb}, 32'd1);
    tick();
    chk("mid_tstate", {26'd0, bif.t_state}, 32'h01);
    nCLR = 1'b1;
    #1;
    chk("mid_no_nLa", {31'd0, bif.nLa}, 32'd1);
    repeat (6) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
